// File: rtl/dram_sim_memory.sv
// Behavioural DRAM device model behind an LPDDR4-style pin bus: command decode, byte-masked
// storage, fixed-latency read return on dq, command counters and sticky error flags.
// Optional macro DRAM_SIM_BANK_EN gives each bank its own storage ({ba, addr} indexing).
module dram_sim_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned BA_WIDTH   = 3,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dram_ck,
  input  logic                    dram_cs,
  input  logic                    dram_ras,
  input  logic                    dram_cas,
  input  logic                    dram_we,
  input  logic [ADDR_WIDTH-1:0]   dram_addr,
  input  logic [BA_WIDTH-1:0]     dram_ba,
  inout  wire  [DATA_WIDTH-1:0]   dram_dq,
  input  logic [DATA_WIDTH/8-1:0] dram_dm,
  input  logic                    dram_dqs,
  output logic [CNT_WIDTH-1:0]    wr_cmd_cnt,
  output logic [CNT_WIDTH-1:0]    rd_cmd_cnt,
  output logic                    err_illegal,
  output logic                    err_contention,
  output logic                    stall_seen
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
`ifdef DRAM_SIM_BANK_EN
  localparam int unsigned IdxWidth = BA_WIDTH + ADDR_WIDTH;
`else
  localparam int unsigned IdxWidth = ADDR_WIDTH;
`endif
  localparam int unsigned Depth = 2 ** IdxWidth;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    CmdNop,
    CmdWrite,
    CmdRead,
    CmdIllegal
  } cmd_e;

  cmd_e                  cmd;
  logic [IdxWidth-1:0]   idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  drv_en;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [DATA_WIDTH-1:0] pipe_data_d [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_vld_d, pipe_vld_q;

  logic [CNT_WIDTH-1:0]  wr_cnt_d, wr_cnt_q;
  logic [CNT_WIDTH-1:0]  rd_cnt_d, rd_cnt_q;
  logic                  err_illegal_d, err_illegal_q;
  logic                  err_cont_d, err_cont_q;
  logic                  ck_d, ck_q;
  logic                  ck_vld_d, ck_vld_q;
  logic                  ck_same_d, ck_same_q;
  logic                  stall_d, stall_q;
  logic                  same_now;

  // Command decode
  always_comb begin
    cmd = CmdNop;
    if (!dram_cs) begin
      case ({dram_ras, dram_cas, dram_we})
        3'b000:  cmd = CmdWrite;
        3'b001:  cmd = CmdRead;
        default: cmd = CmdIllegal;
      endcase
    end
  end

`ifdef DRAM_SIM_BANK_EN
  assign idx = {dram_ba, dram_addr};
  logic unused_inputs;
  assign unused_inputs = dram_dqs;
`else
  // Banks alias onto the same storage
  assign idx = dram_addr;
  logic unused_inputs;
  assign unused_inputs = ^{dram_dqs, dram_ba};
`endif

  // Storage is not reset; writes are blocked while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && (cmd == CmdWrite)) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (!dram_dm[i]) begin
          mem_q[idx][8*i +: 8] <= dram_dq[8*i +: 8];
        end
      end
    end
  end

  // Nonblocking storage update means a read always sees pre-write contents
  assign rd_word = mem_q[idx];

  always_comb begin
    pipe_vld_d[0]  = (cmd == CmdRead);
    pipe_data_d[0] = (cmd == CmdRead) ? rd_word : pipe_data_q[0];
    for (int s = 1; s < RD_LATENCY; s++) begin
      pipe_vld_d[s]  = pipe_vld_q[s-1];
      pipe_data_d[s] = pipe_data_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < RD_LATENCY; s++) begin
      pipe_data_q[s] <= pipe_data_d[s];
    end
  end

  assign drv_en  = pipe_vld_q[RD_LATENCY-1];
  assign dram_dq = drv_en ? pipe_data_q[RD_LATENCY-1] : {DATA_WIDTH{1'bz}};

  // Counters, sticky flags and dram_ck stall detector
  assign same_now = ck_vld_q && (dram_ck == ck_q);

  always_comb begin
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    err_illegal_d = err_illegal_q;
    err_cont_d    = err_cont_q;
    ck_d          = dram_ck;
    ck_vld_d      = 1'b1;
    ck_same_d     = same_now;
    stall_d       = stall_q | (same_now & ck_same_q);
    case (cmd)
      CmdWrite: begin
        wr_cnt_d   = wr_cnt_q + CntOne;
        err_cont_d = err_cont_q | drv_en;
      end
      CmdRead:    rd_cnt_d = rd_cnt_q + CntOne;
      CmdIllegal: err_illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      err_illegal_q <= 1'b0;
      err_cont_q    <= 1'b0;
      ck_q          <= 1'b0;
      ck_vld_q      <= 1'b0;
      ck_same_q     <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      err_illegal_q <= err_illegal_d;
      err_cont_q    <= err_cont_d;
      ck_q          <= ck_d;
      ck_vld_q      <= ck_vld_d;
      ck_same_q     <= ck_same_d;
      stall_q       <= stall_d;
    end
  end

  assign wr_cmd_cnt     = wr_cnt_q;
  assign rd_cmd_cnt     = rd_cnt_q;
  assign err_illegal    = err_illegal_q;
  assign err_contention = err_cont_q;
  assign stall_seen     = stall_q;

endmodule
